seq_bcd_converter: RTL and testbench

- Sequential, parametrised binary-to-BCD converter. Successor to the combinational 8-bit signed converter (sign plus hundreds/tens/ones).
- Uses iterative shift-add-3 (double dabble), one input bit per clock, so WIDTH and digit count scale without a large combinational tree.
- Supports signed (two's complement) and unsigned modes, with a start/busy/done handshake.
- Drives display and UART formatting logic on the FPGA.

---
 rtl/seq_bcd_converter.sv | 142 ++++++++++++++
 tb/tb_seq_bcd_converter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Signed or unsigned input, start/busy/done handshake, results held between conversions.
module seq_bcd_converter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      binary,
   output logic                  busy,
   output logic                  done,
   output logic                  sign_b,
   output logic [4*DIGITS-1:0]   bcd
);

   function automatic int unsigned dec_digits(input longint unsigned v);
      longint unsigned r;
      int unsigned     n;
      r = v;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (r >= 64'd10) begin
            r = r / 64'd10;
            n = n + 1;
         end
      end
      return n;
   endfunction

   localparam int unsigned     BCD_W      = 4 * DIGITS;
   localparam int unsigned     CNT_W      = $clog2(WIDTH);
   localparam longint unsigned MAX_MAG    = (SIGNED != 0) ? (64'd1 << (WIDTH - 1))
                                                          : ((64'd1 << WIDTH) - 64'd1);
   localparam int unsigned     REQ_DIGITS = dec_digits(MAX_MAG);
   localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("seq_bcd_converter: WIDTH=%0d outside 2..32", WIDTH);
   end
   if (DIGITS < REQ_DIGITS) begin : g_bad_digits
      $error("seq_bcd_converter: DIGITS=%0d too small, need %0d", DIGITS, REQ_DIGITS);
   end

   typedef enum logic {IDLE, CONV} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mag_q, mag_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               sign_q, sign_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;

   logic [BCD_W-2:0]   adj;
   logic [BCD_W-1:0]   shifted;
   logic               in_neg;

   // Add-3 per digit; the top digit never exceeds 4 once DIGITS is legal, so its bit 3 is dropped
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      if (i < DIGITS - 1) begin : g_full
         assign adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                               : scratch_q[4*i +: 4];
      end else begin : g_top
         assign adj[4*i +: 3] = (scratch_q[4*i +: 4] >= 4'd5) ? 3'(scratch_q[4*i +: 4] + 4'd3)
                                                               : scratch_q[4*i +: 3];
      end
   end

   assign shifted = {adj, mag_q[WIDTH-1]};
   assign in_neg  = (SIGNED != 0) && binary[WIDTH-1];

   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sign_d    = sign_q;
      bcd_d     = bcd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               neg_d     = in_neg;
               mag_d     = in_neg ? WIDTH'(~binary + WIDTH'(1)) : binary;
               scratch_d = '0;
               cnt_d     = CNT_INIT;
               busy_d    = 1'b1;
               state_d   = CONV;
            end
         end
         CONV: begin
            scratch_d = shifted;
            mag_d     = {mag_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               bcd_d   = shifted;
               sign_d  = neg_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mag_q     <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sign_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         state_q   <= state_d;
         mag_q     <= mag_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sign_q    <= sign_d;
         bcd_q     <= bcd_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign sign_b = sign_q;
   assign bcd    = bcd_q;

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Bench for seq_bcd_converter: four configurations against an arithmetic model,
// plus directed literal checks of latency, handshake and reset behaviour.
module tb_seq_bcd_converter;

   localparam int unsigned MW [4] = '{8, 8, 16, 16};
   localparam bit          MS [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        chk_en;
   logic [3:0]  st;
   logic [15:0] bin [4];
   logic [3:0]  busy_a, done_a, sign_a;
   logic [11:0] bcd0, bcd1;
   logic [19:0] bcd2, bcd3;
   logic [19:0] bcd_a [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_s8 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .binary(bin[0][7:0]),
      .busy(busy_a[0]), .done(done_a[0]), .sign_b(sign_a[0]), .bcd(bcd0));
   seq_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_u8 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .binary(bin[1][7:0]),
      .busy(busy_a[1]), .done(done_a[1]), .sign_b(sign_a[1]), .bcd(bcd1));
   seq_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_s16 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .binary(bin[2]),
      .busy(busy_a[2]), .done(done_a[2]), .sign_b(sign_a[2]), .bcd(bcd2));
   seq_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_u16 (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .binary(bin[3]),
      .busy(busy_a[3]), .done(done_a[3]), .sign_b(sign_a[3]), .bcd(bcd3));

   assign bcd_a[0] = 20'(bcd0);
   assign bcd_a[1] = 20'(bcd1);
   assign bcd_a[2] = bcd2;
   assign bcd_a[3] = bcd3;

   // Decimal digits by repeated division
   function automatic logic [19:0] gold(input int unsigned x);
      logic [19:0]  r;
      int unsigned  v;
      r = '0;
      v = x;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int unsigned mag_of(input int k, input logic [15:0] x);
      int unsigned full, v;
      full = 32'd1 << MW[k];
      v    = 32'(x) % full;
      if (MS[k] && v >= full / 2) return full - v;
      return v;
   endfunction

   function automatic logic neg_of(input int k, input logic [15:0] x);
      int unsigned full, v;
      full = 32'd1 << MW[k];
      v    = 32'(x) % full;
      return MS[k] && (v >= full / 2);
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Transaction-level model: accept when idle, publish result WIDTH edges later
   int unsigned m_cnt [4];
   logic        m_busy [4], m_done [4], m_sign [4], m_psign [4];
   logic [19:0] m_bcd [4], m_pbcd [4];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 4; k++) begin
         if (!rst_n) begin
            m_cnt[k]  = 0;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_sign[k] = 1'b0;
            m_bcd[k]  = '0;
         end else if (m_busy[k]) begin
            m_cnt[k] = m_cnt[k] - 1;
            if (m_cnt[k] == 0) begin
               m_busy[k] = 1'b0;
               m_done[k] = 1'b1;
               m_bcd[k]  = m_pbcd[k];
               m_sign[k] = m_psign[k];
            end
         end else begin
            m_done[k] = 1'b0;
            if (st[k]) begin
               m_busy[k]  = 1'b1;
               m_cnt[k]   = MW[k];
               m_pbcd[k]  = gold(mag_of(k, bin[k]));
               m_psign[k] = neg_of(k, bin[k]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            check("busy", k, 32'(busy_a[k]), 32'(m_busy[k]));
            check("done", k, 32'(done_a[k]), 32'(m_done[k]));
            check("sign_b", k, 32'(sign_a[k]), 32'(m_sign[k]));
            check("bcd", k, 32'(bcd_a[k]), 32'(m_bcd[k]));
         end
      end
   end

   // Start one conversion and wait for done; returns edges to done and cycles busy was seen
   task automatic run(input int k, input logic [15:0] v, output int lat, output int nb);
      @(posedge clk);
      #1 st[k] = 1'b1;
      bin[k] = v;
      @(posedge clk);
      #1 st[k] = 1'b0;
      lat = 0;
      nb  = int'(busy_a[k]);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 lat++;
         if (done_a[k]) break;
         nb += int'(busy_a[k]);
      end
      if (!done_a[k]) check("done_timeout", k, 32'd0, 32'd1);
   endtask

   int lat, nb, nd;

   initial begin
      rst_n  = 1'b1;
      chk_en = 1'b0;
      st     = '0;
      for (int k = 0; k < 4; k++) bin[k] = '0;
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      check("rst_busy", 0, 32'(busy_a[0]), 32'd0);
      check("rst_done", 0, 32'(done_a[0]), 32'd0);
      check("rst_sign", 0, 32'(sign_a[0]), 32'd0);
      check("rst_bcd", 0, 32'(bcd0), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Most negative and most positive 8-bit values
      run(0, 16'h0080, lat, nb);
      check("lat_80", 0, 32'(lat), 32'd8);
      check("busy_cycles_80", 0, 32'(nb), 32'd8);
      check("sign_80", 0, 32'(sign_a[0]), 32'd1);
      check("bcd_80", 0, 32'(bcd0), 32'h128);
      run(0, 16'h007F, lat, nb);
      check("sign_7f", 0, 32'(sign_a[0]), 32'd0);
      check("bcd_7f", 0, 32'(bcd0), 32'h127);
      run(0, 16'h00FF, lat, nb);
      check("sign_ff", 0, 32'(sign_a[0]), 32'd1);
      check("bcd_ff", 0, 32'(bcd0), 32'h001);
      run(0, 16'h0000, lat, nb);
      check("sign_00", 0, 32'(sign_a[0]), 32'd0);
      check("bcd_00", 0, 32'(bcd0), 32'h000);

      // Every signed 8-bit input, checked by the model
      for (int v = 0; v < 256; v++) run(0, 16'(v), lat, nb);

      // Start while busy is ignored; start during the done cycle is accepted
      @(posedge clk);
      #1 st[0] = 1'b1;
      bin[0] = 16'd45;
      @(posedge clk);
      #1 st[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 st[0] = 1'b1;
      bin[0] = 16'd99;
      @(posedge clk);
      #1 st[0] = 1'b0;
      for (int i = 0; i < 20 && !done_a[0]; i++) begin
         @(posedge clk);
         #1;
      end
      check("hs_done1", 0, 32'(done_a[0]), 32'd1);
      check("hs_bcd1", 0, 32'(bcd0), 32'h045);
      check("hs_sign1", 0, 32'(sign_a[0]), 32'd0);
      st[0] = 1'b1;
      bin[0] = 16'h00F6;
      @(posedge clk);
      #1 st[0] = 1'b0;
      check("hs_b2b_busy", 0, 32'(busy_a[0]), 32'd1);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 lat++;
         if (done_a[0]) break;
      end
      check("hs_lat2", 0, 32'(lat), 32'd8);
      check("hs_bcd2", 0, 32'(bcd0), 32'h010);
      check("hs_sign2", 0, 32'(sign_a[0]), 32'd1);

      // Unsigned 8-bit: MSB set is not a sign
      run(1, 16'h00FF, lat, nb);
      check("u8_sign_ff", 1, 32'(sign_a[1]), 32'd0);
      check("u8_bcd_ff", 1, 32'(bcd1), 32'h255);

      // Reset in the middle of a conversion
      @(posedge clk);
      #1 st[1] = 1'b1;
      bin[1] = 16'd200;
      @(posedge clk);
      #1 st[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("mid_busy_pre", 1, 32'(busy_a[1]), 32'd1);
      rst_n = 1'b0;
      #1 check("mid_busy", 1, 32'(busy_a[1]), 32'd0);
      check("mid_done", 1, 32'(done_a[1]), 32'd0);
      check("mid_sign", 1, 32'(sign_a[1]), 32'd0);
      check("mid_bcd", 1, 32'(bcd1), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      nd = 0;
      repeat (12) begin
         @(posedge clk);
         #1 nd += int'(done_a[1]);
      end
      check("mid_no_done", 1, 32'(nd), 32'd0);
      run(1, 16'd200, lat, nb);
      check("u8_lat_200", 1, 32'(lat), 32'd8);
      check("u8_bcd_200", 1, 32'(bcd1), 32'h200);

      // 16-bit configurations
      run(2, 16'h8000, lat, nb);
      check("s16_lat", 2, 32'(lat), 32'd16);
      check("s16_sign_8000", 2, 32'(sign_a[2]), 32'd1);
      check("s16_bcd_8000", 2, 32'(bcd2), 32'h32768);
      run(2, 16'h7FFF, lat, nb);
      check("s16_sign_7fff", 2, 32'(sign_a[2]), 32'd0);
      check("s16_bcd_7fff", 2, 32'(bcd2), 32'h32767);
      run(3, 16'hFFFF, lat, nb);
      check("u16_sign_ffff", 3, 32'(sign_a[3]), 32'd0);
      check("u16_bcd_ffff", 3, 32'(bcd3), 32'h65535);
      run(3, 16'd10000, lat, nb);
      check("u16_bcd_10000", 3, 32'(bcd3), 32'h10000);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
